// File: rtl/cond_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_issue_ctrl_pkg
// Description : Shared definitions for the condition-execution issue
//               controller: condition code values, NZCV bit positions and
//               the flag-hazard state encoding.
// Contents    : COND_EQ..COND_AL, COND_NV  - 4-bit condition field values
//               FLAG_N/Z/C/V               - bit indices inside an NZCV nibble
//               ST_IDLE/ST_PEND            - 1-bit state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package cond_issue_ctrl_pkg;

  localparam int COND_W = 4;
  localparam int FLAG_W = 4;

  // Condition field encodings
  localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
  localparam logic [COND_W-1:0] COND_NE = 4'b0001;
  localparam logic [COND_W-1:0] COND_CS = 4'b0010;
  localparam logic [COND_W-1:0] COND_CC = 4'b0011;
  localparam logic [COND_W-1:0] COND_MI = 4'b0100;
  localparam logic [COND_W-1:0] COND_PL = 4'b0101;
  localparam logic [COND_W-1:0] COND_VS = 4'b0110;
  localparam logic [COND_W-1:0] COND_VC = 4'b0111;
  localparam logic [COND_W-1:0] COND_HI = 4'b1000;
  localparam logic [COND_W-1:0] COND_LS = 4'b1001;
  localparam logic [COND_W-1:0] COND_GE = 4'b1010;
  localparam logic [COND_W-1:0] COND_LT = 4'b1011;
  localparam logic [COND_W-1:0] COND_GT = 4'b1100;
  localparam logic [COND_W-1:0] COND_LE = 4'b1101;
  localparam logic [COND_W-1:0] COND_AL = 4'b1110;
  localparam logic [COND_W-1:0] COND_NV = 4'b1111;

  // NZCV bit positions
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Flag-hazard tracker states
  localparam logic [0:0] ST_IDLE = 1'b0;  // no flag writer outstanding
  localparam logic [0:0] ST_PEND = 1'b1;  // one flag writer in flight

endpackage : cond_issue_ctrl_pkg
`default_nettype wire

// File: rtl/cond_issue_ctrl_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Purely combinational condition-code evaluator. Decides
//               whether an instruction with condition field i_cond executes
//               given the NZCV flags i_flags.
// Ports       : i_cond  [3:0] in  - condition field
//               i_flags [3:0] in  - NZCV (bit 3..0)
//               o_pass        out - 1 = execute, 0 = treat as NOP
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
  import cond_issue_ctrl_pkg::*;
(
  input  logic [COND_W-1:0] i_cond,
  input  logic [FLAG_W-1:0] i_flags,
  output logic              o_pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      // Never-execute: a clean 0 rather than anything undefined
      default: o_pass = 1'b0;
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/cond_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cond_issue_ctrl
// Description : Condition-execution issue controller between decode and
//               execute. Owns the architectural NZCV register, evaluates
//               each decoded instruction's condition against current or
//               forwarded flags, tracks the single outstanding flag-setting
//               ALU operation and stalls decode on a flag hazard. Drives a
//               registered valid/execute/set-flags triple to execute.
// Ports       : clk, rst          in  - clock (rising), sync active-high reset
//               idValid           in  - decode holds an instruction
//               idCond  [3:0]     in  - condition field
//               idS               in  - instruction updates flags
//               idReady           out - decode instruction accepted this cycle
//               exStall           in  - execute holding; freeze issue slot
//               flush             in  - kill decode instruction and issue slot
//               aluDone           in  - outstanding writer delivers flags
//               aluFlags [3:0]    in  - NZCV from ALU, valid with aluDone
//               exValid           out - issue slot occupied
//               exExec            out - condition passed (0 = NOP)
//               exS               out - issued instruction sets flags
//               statusReg [3:0]   out - architectural NZCV
// Revision    : 1.0 - initial release
// ============================================================================
module cond_issue_ctrl
  import cond_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              idValid,
  input  logic [COND_W-1:0] idCond,
  input  logic              idS,
  output logic              idReady,
  input  logic              exStall,
  input  logic              flush,
  input  logic              aluDone,
  input  logic [FLAG_W-1:0] aluFlags,
  output logic              exValid,
  output logic              exExec,
  output logic              exS,
  output logic [FLAG_W-1:0] statusReg
);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;

  logic [FLAG_W-1:0] r_status;
  logic              r_ex_valid;
  logic              r_ex_exec;
  logic              r_ex_s;

  logic              w_pend;      // a flag writer is in flight
  logic              w_fwd;       // its flags arrive this cycle
  logic              w_hazard;    // decode would read stale flags
  logic [FLAG_W-1:0] w_eval_flags;
  logic              w_pass;
  logic              w_ready;
  logic              w_issue;
  logic              w_issue_s;   // issuing instruction will write flags

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // A new writer issuing in the same cycle the old one completes keeps the
  // tracker in PEND, so there is never more than one writer outstanding.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_issue_s) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (aluDone && !w_issue_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / hazard logic
  // aluDone only means something while a writer is pending; in IDLE it is
  // neither forwarded nor written into statusReg.
  // --------------------------------------------------------------------------
  always_comb begin
    w_pend   = (r_state == ST_PEND);
    w_fwd    = w_pend && aluDone;
    // AL without S does not read or write flags, so it may pass a pending
    // writer; everything else waits for the writer's flags.
    w_hazard = w_pend && !aluDone && ((idCond != COND_AL) || idS);
  end

  // --------------------------------------------------------------------------
  // Condition evaluation on forwarded or architectural flags
  // --------------------------------------------------------------------------
  assign w_eval_flags = w_fwd ? aluFlags : r_status;

  cond_eval u_cond_eval (
    .i_cond  (idCond),
    .i_flags (w_eval_flags),
    .o_pass  (w_pass)
  );

  assign w_ready   = !exStall && !flush && !w_hazard;
  assign w_issue   = idValid && w_ready;
  // A setter whose condition fails is a NOP and must not create a hazard
  assign w_issue_s = w_issue && w_pass && idS;

  // --------------------------------------------------------------------------
  // Architectural flags: written by the pending writer regardless of stall
  // or flush, since that writer is older than anything being killed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
    end else if (w_fwd) begin
      r_status <= aluFlags;
    end
  end

  // --------------------------------------------------------------------------
  // Issue slot registers. Flush wins over stall.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_exec  <= 1'b0;
      r_ex_s     <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
      r_ex_exec  <= 1'b0;
      r_ex_s     <= 1'b0;
    end else if (exStall) begin
      r_ex_valid <= r_ex_valid;
      r_ex_exec  <= r_ex_exec;
      r_ex_s     <= r_ex_s;
    end else if (w_issue) begin
      r_ex_valid <= 1'b1;
      r_ex_exec  <= w_pass;
      r_ex_s     <= w_pass && idS;
    end else begin
      r_ex_valid <= 1'b0;
      r_ex_exec  <= 1'b0;
      r_ex_s     <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign idReady   = w_ready;
  assign exValid   = r_ex_valid;
  assign exExec    = r_ex_exec;
  assign exS       = r_ex_s;
  assign statusReg = r_status;

endmodule : cond_issue_ctrl
`default_nettype wire

// File: doc/cond_issue_ctrl.md
# cond_issue_ctrl

Condition-execution issue controller between decode and execute. It owns the NZCV status register and evaluates each decoded instruction's 4-bit condition field against current or forwarded flags. It tracks the single outstanding flag-setting ALU operation and stalls decode while a dependent instruction would read stale flags. It hands execute a registered valid/execute/set-flags triple.

## Interface
- No parameters; flag width 4 (N,Z,C,V, bit 3..0), condition width 4.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- idValid  in  1  decode holds an instruction.
- idCond  in  4  condition field.
- idS  in  1  instruction updates flags.
- idReady  out  1  controller accepts decode instruction this cycle.
- exStall  in  1  execute cannot take a new instruction; hold outputs.
- flush  in  1  branch taken; kill decode instruction and issue slot.
- aluDone  in  1  outstanding flag writer produces its flags this cycle.
- aluFlags  in  4  NZCV from ALU, valid with aluDone.
- exValid  out  1  issue slot occupied.
- exExec  out  1  condition passed; 0 = execute as NOP.
- exS  out  1  issued instruction will set flags (exExec && idS).
- statusReg  out  4  architectural NZCV.

## Operation
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 is never-execute, so exExec=0 (defined, never X/Z).
- Flag source for evaluation: aluFlags if aluDone, else statusReg.
- Two states:
  - IDLE: no flag writer outstanding.
  - PEND: a flag writer is issued and its aluDone has not arrived.
- Transitions:
  - IDLE->PEND when an instruction issues with exS=1.
  - PEND->IDLE on aluDone, unless an exS=1 instruction issues the same cycle (stay PEND).
  - aluDone in IDLE is ignored. It does not update statusReg.
- Hazard: in PEND without aluDone, idReady=0 if idCond!=1110 or idS=1. At most one outstanding writer.
- AL instructions without S issue freely in PEND.
- A flag-setting instruction whose condition fails does not set flags: exS=0 and no PEND entry.
- idReady = !exStall && !flush && !hazard. An instruction issues when idValid && idReady.
- statusReg <= aluFlags on aluDone in PEND, independent of exStall and flush.

## Timing
- Reset values: statusReg=0000, exValid=0, exExec=0, exS=0, state IDLE. idReady is combinational and reflects IDLE after reset.
- Issue latency 1 cycle: ex* registered at the edge where issue occurs.
- exStall=1: ex* hold their values and idReady=0.
- No issue and no stall: exValid<=0, exExec<=0, exS<=0.
- flush=1: at the next edge exValid, exExec and exS clear, even with exStall. State and statusReg are unaffected, because the pending writer is older than the branch.
- aluDone with dependent instruction in the same cycle: forwarded flags are used, the instruction issues with no bubble, and statusReg updates at the same edge.
- rst mid-PEND: returns to IDLE; a later aluDone is ignored.

## Structure
- Shared package holds:
  - condition code localparams (COND_EQ..COND_AL, COND_NV);
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0);
  - state encoding (ST_IDLE, ST_PEND).
- One sub-module, cond_eval: purely combinational (cond, flags -> pass).
- Top block holds the state register, statusReg, hazard logic and issue registers.

## Test plan
- Reset, then idValid=1, idCond=1110, idS=0 -> next cycle exValid=1, exExec=1, exS=0, statusReg=0000.
- All 16 codes against all 16 NZCV values loaded via a flag writer: exExec matches the code table; code 1111 always gives exExec=0.
- Issue cond AL with S=1, then cond EQ while no aluDone -> idReady=0 for 3 cycles. Then aluDone with aluFlags=0100 -> EQ issues the same cycle with exExec=1, and statusReg=0100 next cycle.
- S=1 with cond NE while Z=1 -> exExec=0, exS=0, state stays IDLE. A following EQ issues with no stall.
- exStall=1 for 2 cycles with an instruction in the slot -> ex* held and idReady=0. flush during stall -> exValid=0 next cycle, statusReg unchanged.
- rst asserted in PEND, then aluDone=1 with aluFlags=1111 -> statusReg stays 0000 and state is IDLE.
